reg_file: RTL and testbench

- Architectural register file with rename tags for the out-of-order core.
- Sits on the far side of the ROB rename/commit interface:
  - accepts rename allocations when the decoder issues an instruction;
  - accepts value writes when the ROB commits its head;
  - returns tags to the ROB for its rs lookups.
- Supplies operand values, or ROB tags plus a busy flag, to the decoder.
- Flushes all rename state on branch/JALR mispredict.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_read_port.sv | 40 ++++
 rtl/reg_file.sv | 94 +++++++++
 tb/tb_reg_file.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared widths and helpers for the rename-aware architectural register file.
// Ports, tags and index ranges in reg_file and its read ports all derive from here.
package reg_file_pkg;

   localparam int XLEN      = 32;
   localparam int REG_NUM   = 32;
   localparam int REG_IDX_W = 5;
   localparam int ROB_IDX_W = 4;

   localparam logic [XLEN-1:0] ZERO32 = '0;

   function automatic logic is_x0(input logic [REG_IDX_W-1:0] r);
      return (r == '0);
   endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One source-operand read port: selects a committed value, a same-cycle commit
// bypass, or a busy flag plus rename tag for a single architectural register.
module reg_file_read_port
   import reg_file_pkg::*;
(
   input  logic [REG_IDX_W-1:0] rs_i,
   input  logic [XLEN-1:0]      reg_val_i,
   input  logic                 reg_busy_i,
   input  logic [ROB_IDX_W-1:0] reg_tag_i,
   input  logic                 write_flag_i,
   input  logic [REG_IDX_W-1:0] write_rd_i,
   input  logic [ROB_IDX_W-1:0] write_idx_i,
   input  logic [XLEN-1:0]      write_val_i,
   output logic [XLEN-1:0]      val_o,
   output logic                 busy_o,
   output logic [ROB_IDX_W-1:0] idx_o
);

   logic hit;

   // A commit to this register forwards only if it is the newest producer,
   // or if nothing newer has renamed the register.
   assign hit = write_flag_i && (write_rd_i == rs_i) &&
                (!reg_busy_i || (reg_tag_i == write_idx_i));

   always_comb begin
      val_o  = reg_val_i;
      busy_o = reg_busy_i;
      idx_o  = reg_tag_i;
      if (is_x0(rs_i)) begin
         val_o  = ZERO32;
         busy_o = 1'b0;
         idx_o  = '0;
      end else if (hit) begin
         val_o  = write_val_i;
         busy_o = 1'b0;
      end
   end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with ROB rename tags: commit writes, rename
// allocation, mispredict flush, and two combinational decoder read ports.
module reg_file
   import reg_file_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rdy,
   input  logic                 jump_wrong,
   input  logic [REG_IDX_W-1:0] Dec_rs1_in,
   input  logic [REG_IDX_W-1:0] Dec_rs2_in,
   output logic [XLEN-1:0]      Dec_rs1_val_out,
   output logic                 Dec_rs1_busy_out,
   output logic [XLEN-1:0]      Dec_rs2_val_out,
   output logic                 Dec_rs2_busy_out,
   output logic [ROB_IDX_W-1:0] ROB_rs1_idx_out,
   output logic [ROB_IDX_W-1:0] ROB_rs2_idx_out,
   input  logic                 ROB_new_flag_in,
   input  logic [ROB_IDX_W-1:0] ROB_new_idx_in,
   input  logic [REG_IDX_W-1:0] ROB_new_rd_in,
   input  logic                 ROB_write_flag_in,
   input  logic [ROB_IDX_W-1:0] ROB_write_idx_in,
   input  logic [REG_IDX_W-1:0] ROB_write_rd_in,
   input  logic [XLEN-1:0]      ROB_val_in
);

   logic [REG_NUM-1:0][XLEN-1:0]      regs_q, regs_d;
   logic [REG_NUM-1:0][ROB_IDX_W-1:0] tag_q, tag_d;
   logic [REG_NUM-1:0]                busy_q, busy_d;

   logic commit_en, rename_en;

   assign commit_en = ROB_write_flag_in && !is_x0(ROB_write_rd_in);
   assign rename_en = ROB_new_flag_in && !is_x0(ROB_new_rd_in) && !jump_wrong;

   // Commit is applied first so a same-edge rename of the same register wins busy/tag.
   always_comb begin
      regs_d = regs_q;
      tag_d  = tag_q;
      busy_d = busy_q;
      if (commit_en) begin
         regs_d[ROB_write_rd_in] = ROB_val_in;
         if (busy_q[ROB_write_rd_in] && (tag_q[ROB_write_rd_in] == ROB_write_idx_in))
            busy_d[ROB_write_rd_in] = 1'b0;
      end
      if (jump_wrong) begin
         busy_d = '0;
      end else if (rename_en) begin
         busy_d[ROB_new_rd_in] = 1'b1;
         tag_d[ROB_new_rd_in]  = ROB_new_idx_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
         tag_q  <= '0;
         busy_q <= '0;
      end else if (rdy) begin
         regs_q <= regs_d;
         tag_q  <= tag_d;
         busy_q <= busy_d;
      end
   end

   reg_file_read_port u_rs1 (
      .rs_i         (Dec_rs1_in),
      .reg_val_i    (regs_q[Dec_rs1_in]),
      .reg_busy_i   (busy_q[Dec_rs1_in]),
      .reg_tag_i    (tag_q[Dec_rs1_in]),
      .write_flag_i (ROB_write_flag_in),
      .write_rd_i   (ROB_write_rd_in),
      .write_idx_i  (ROB_write_idx_in),
      .write_val_i  (ROB_val_in),
      .val_o        (Dec_rs1_val_out),
      .busy_o       (Dec_rs1_busy_out),
      .idx_o        (ROB_rs1_idx_out)
   );

   reg_file_read_port u_rs2 (
      .rs_i         (Dec_rs2_in),
      .reg_val_i    (regs_q[Dec_rs2_in]),
      .reg_busy_i   (busy_q[Dec_rs2_in]),
      .reg_tag_i    (tag_q[Dec_rs2_in]),
      .write_flag_i (ROB_write_flag_in),
      .write_rd_i   (ROB_write_rd_in),
      .write_idx_i  (ROB_write_idx_in),
      .write_val_i  (ROB_val_in),
      .val_o        (Dec_rs2_val_out),
      .busy_o       (Dec_rs2_busy_out),
      .idx_o        (ROB_rs2_idx_out)
   );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register/rename state.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rdy;
   logic        jump_wrong;
   logic [4:0]  Dec_rs1_in, Dec_rs2_in;
   logic [31:0] Dec_rs1_val_out, Dec_rs2_val_out;
   logic        Dec_rs1_busy_out, Dec_rs2_busy_out;
   logic [3:0]  ROB_rs1_idx_out, ROB_rs2_idx_out;
   logic        ROB_new_flag_in;
   logic [3:0]  ROB_new_idx_in;
   logic [4:0]  ROB_new_rd_in;
   logic        ROB_write_flag_in;
   logic [3:0]  ROB_write_idx_in;
   logic [4:0]  ROB_write_rd_in;
   logic [31:0] ROB_val_in;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_regs [32];
   logic [3:0]  m_tag  [32];
   logic        m_busy [32];

   always #5 clk = ~clk;

   reg_file dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .rdy               (rdy),
      .jump_wrong        (jump_wrong),
      .Dec_rs1_in        (Dec_rs1_in),
      .Dec_rs2_in        (Dec_rs2_in),
      .Dec_rs1_val_out   (Dec_rs1_val_out),
      .Dec_rs1_busy_out  (Dec_rs1_busy_out),
      .Dec_rs2_val_out   (Dec_rs2_val_out),
      .Dec_rs2_busy_out  (Dec_rs2_busy_out),
      .ROB_rs1_idx_out   (ROB_rs1_idx_out),
      .ROB_rs2_idx_out   (ROB_rs2_idx_out),
      .ROB_new_flag_in   (ROB_new_flag_in),
      .ROB_new_idx_in    (ROB_new_idx_in),
      .ROB_new_rd_in     (ROB_new_rd_in),
      .ROB_write_flag_in (ROB_write_flag_in),
      .ROB_write_idx_in  (ROB_write_idx_in),
      .ROB_write_rd_in   (ROB_write_rd_in),
      .ROB_val_in        (ROB_val_in)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_tag[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   // Expected decoder view of one source given the model state and current commit inputs.
   task automatic model_read(input logic [4:0] rs, output logic [31:0] val,
                             output logic busy, output logic [3:0] idx);
      if (rs == 0) begin
         val = 0; busy = 0; idx = 0;
      end else begin
         idx = m_tag[rs];
         if (ROB_write_flag_in && ROB_write_rd_in == rs &&
             (!m_busy[rs] || m_tag[rs] == ROB_write_idx_in)) begin
            val = ROB_val_in; busy = 0;
         end else begin
            val = m_regs[rs]; busy = m_busy[rs];
         end
      end
   endtask

   task automatic model_edge();
      logic [4:0] w, n;
      if (!rst_n || !rdy) return;
      w = ROB_write_rd_in;
      n = ROB_new_rd_in;
      if (ROB_write_flag_in && w != 0) begin
         m_regs[w] = ROB_val_in;
         if (m_busy[w] && m_tag[w] == ROB_write_idx_in) m_busy[w] = 1'b0;
      end
      if (jump_wrong) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (ROB_new_flag_in && n != 0) begin
         m_busy[n] = 1'b1;
         m_tag[n]  = ROB_new_idx_in;
      end
   endtask

   task automatic check_reads(input string tag);
      logic [31:0] v; logic b; logic [3:0] ix;
      model_read(Dec_rs1_in, v, b, ix);
      check({tag, ".rs1_val"},  Dec_rs1_val_out, v);
      check({tag, ".rs1_busy"}, {31'b0, Dec_rs1_busy_out}, {31'b0, b});
      check({tag, ".rs1_idx"},  {28'b0, ROB_rs1_idx_out}, {28'b0, ix});
      model_read(Dec_rs2_in, v, b, ix);
      check({tag, ".rs2_val"},  Dec_rs2_val_out, v);
      check({tag, ".rs2_busy"}, {31'b0, Dec_rs2_busy_out}, {31'b0, b});
      check({tag, ".rs2_idx"},  {28'b0, ROB_rs2_idx_out}, {28'b0, ix});
   endtask

   task automatic idle();
      rdy = 1; jump_wrong = 0;
      Dec_rs1_in = 0; Dec_rs2_in = 0;
      ROB_new_flag_in = 0; ROB_new_idx_in = 0; ROB_new_rd_in = 0;
      ROB_write_flag_in = 0; ROB_write_idx_in = 0; ROB_write_rd_in = 0; ROB_val_in = 0;
   endtask

   task automatic settle(input string tag);
      #1;
      check_reads(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic expect_rs1(input string tag, input logic [31:0] v,
                             input logic b, input logic [3:0] ix);
      check({tag, ".val"},  Dec_rs1_val_out, v);
      check({tag, ".busy"}, {31'b0, Dec_rs1_busy_out}, {31'b0, b});
      check({tag, ".idx"},  {28'b0, ROB_rs1_idx_out}, {28'b0, ix});
   endtask

   initial begin
      idle();
      rst_n = 0;
      model_reset();
      #12;
      rst_n = 1;
      tick();

      // Reset state and a plain commit
      Dec_rs1_in = 5; Dec_rs2_in = 31;
      settle("rst"); expect_rs1("rst_x5", 0, 0, 0);
      ROB_write_flag_in = 1; ROB_write_idx_in = 3; ROB_write_rd_in = 5; ROB_val_in = 32'h1234;
      Dec_rs1_in = 0; Dec_rs2_in = 0;
      settle("commit5"); tick();
      idle(); Dec_rs1_in = 5;
      settle("rd5"); expect_rs1("rd_x5", 32'h1234, 0, 3'd0);

      // Rename then commit with bypass
      ROB_new_flag_in = 1; ROB_new_rd_in = 7; ROB_new_idx_in = 9;
      settle("ren7"); tick();
      idle(); Dec_rs1_in = 7;
      settle("busy7"); expect_rs1("busy_x7", 0, 1, 9);
      ROB_write_flag_in = 1; ROB_write_idx_in = 9; ROB_write_rd_in = 7; ROB_val_in = 32'hAB;
      settle("byp7"); expect_rs1("bypass_x7", 32'hAB, 0, 9);
      tick();
      idle(); Dec_rs1_in = 7;
      settle("post7"); expect_rs1("post_x7", 32'hAB, 0, 9);

      // Stale commit after a younger rename
      ROB_new_flag_in = 1; ROB_new_rd_in = 7; ROB_new_idx_in = 9; tick();
      ROB_new_idx_in = 11; tick();
      idle(); Dec_rs1_in = 7;
      ROB_write_flag_in = 1; ROB_write_idx_in = 9; ROB_write_rd_in = 7; ROB_val_in = 32'h55;
      settle("stale7"); expect_rs1("stale_byp_x7", 32'hAB, 1, 11);
      tick();
      idle(); Dec_rs1_in = 7;
      settle("stale7b"); expect_rs1("stale_x7", 32'h55, 1, 11);

      // Same-edge commit and rename of one register
      ROB_new_flag_in = 1; ROB_new_rd_in = 4; ROB_new_idx_in = 2; tick();
      idle();
      ROB_write_flag_in = 1; ROB_write_idx_in = 2; ROB_write_rd_in = 4; ROB_val_in = 32'h10;
      ROB_new_flag_in = 1; ROB_new_rd_in = 4; ROB_new_idx_in = 6;
      settle("same4"); tick();
      idle(); Dec_rs1_in = 4;
      settle("same4b"); expect_rs1("same_x4", 32'h10, 1, 6);

      // Flush with simultaneous commit and discarded rename
      for (int r = 1; r <= 3; r++) begin
         ROB_new_flag_in = 1; ROB_new_rd_in = 5'(r); ROB_new_idx_in = 4'(r); tick();
      end
      idle(); jump_wrong = 1;
      ROB_write_flag_in = 1; ROB_write_idx_in = 1; ROB_write_rd_in = 1; ROB_val_in = 32'h99;
      ROB_new_flag_in = 1; ROB_new_rd_in = 8; ROB_new_idx_in = 5;
      settle("flush"); tick();
      idle(); Dec_rs1_in = 1; Dec_rs2_in = 8;
      settle("flushb"); expect_rs1("flush_x1", 32'h99, 0, 1);
      check("flush_x8_busy", {31'b0, Dec_rs2_busy_out}, 32'd0);
      Dec_rs1_in = 3; Dec_rs2_in = 4;
      settle("flushc");
      check("flush_x3_busy", {31'b0, Dec_rs1_busy_out}, 32'd0);
      check("flush_x4_busy", {31'b0, Dec_rs2_busy_out}, 32'd0);

      // x0 is hardwired
      ROB_write_flag_in = 1; ROB_write_rd_in = 0; ROB_write_idx_in = 7; ROB_val_in = 32'hFFFF_FFFF;
      ROB_new_flag_in = 1; ROB_new_rd_in = 0; ROB_new_idx_in = 7;
      Dec_rs1_in = 0;
      settle("x0"); expect_rs1("x0_byp", 0, 0, 0);
      tick();
      idle(); Dec_rs1_in = 0;
      settle("x0b"); expect_rs1("x0_after", 0, 0, 0);

      // rdy low holds state
      rdy = 0;
      ROB_write_flag_in = 1; ROB_write_rd_in = 9; ROB_write_idx_in = 0; ROB_val_in = 32'hDEAD;
      ROB_new_flag_in = 1; ROB_new_rd_in = 10; ROB_new_idx_in = 3;
      tick();
      idle(); Dec_rs1_in = 9; Dec_rs2_in = 10;
      settle("hold"); expect_rs1("hold_x9", 0, 0, 0);
      check("hold_x10_busy", {31'b0, Dec_rs2_busy_out}, 32'd0);

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         logic [4:0] w;
         idle();
         rdy = ($urandom_range(0, 9) != 0);
         jump_wrong = ($urandom_range(0, 19) == 0);
         Dec_rs1_in = 5'($urandom); Dec_rs2_in = 5'($urandom);
         ROB_new_flag_in = $urandom_range(0, 1) == 1;
         ROB_new_rd_in = 5'($urandom); ROB_new_idx_in = 4'($urandom);
         ROB_write_flag_in = $urandom_range(0, 1) == 1;
         w = ($urandom_range(0, 1) == 1) ? Dec_rs1_in : 5'($urandom);
         ROB_write_rd_in = w;
         ROB_write_idx_in = (m_busy[w] && $urandom_range(0, 2) != 0) ? m_tag[w] : 4'($urandom);
         ROB_val_in = $urandom;
         settle("rnd");
         tick();
      end

      // Asynchronous reset mid-cycle
      idle();
      ROB_write_flag_in = 1; ROB_write_rd_in = 5; ROB_write_idx_in = 0; ROB_val_in = 32'h1234;
      ROB_new_flag_in = 1; ROB_new_rd_in = 6; ROB_new_idx_in = 12;
      tick();
      idle(); Dec_rs1_in = 5; Dec_rs2_in = 6;
      #2;
      rst_n = 0;
      model_reset();
      settle("arst"); expect_rs1("arst_x5", 0, 0, 0);
      check("arst_x6_busy", {31'b0, Dec_rs2_busy_out}, 32'd0);
      rst_n = 1;
      tick();
      settle("arst_after"); expect_rs1("arst_after_x5", 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
